// File: rtl/result_drain.sv
`default_nettype none
// ============================================================================
// Module   : result_drain
// Purpose  : Output stage of the 2x2 matrix multiplier. Snapshots the four
//            accumulator results on res_valid, then emits them either as four
//            raw 32-bit words or as one packed word of requantized int8
//            values (round half up, arithmetic shift, saturate). Words go into
//            a first-word-fall-through FIFO drained with a valid/ready
//            handshake.
// Ports    : clk, reset (async, active-high)
//            res_valid, z11..z22, shift, packed_mode   - result capture side
//            rd_data, rd_valid, rd_ready, fifo_count   - bus-side FIFO reader
//            busy, overflow, clr_overflow              - status / control
// Revision : 1.0 - initial release
// ============================================================================
module result_drain #(
  parameter int ACC_W      = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          res_valid,
  input  logic [ACC_W-1:0]              z11,
  input  logic [ACC_W-1:0]              z12,
  input  logic [ACC_W-1:0]              z21,
  input  logic [ACC_W-1:0]              z22,
  input  logic [4:0]                    shift,
  input  logic                          packed_mode,
  output logic [31:0]                   rd_data,
  output logic                          rd_valid,
  input  logic                          rd_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy,
  output logic                          overflow,
  input  logic                          clr_overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'(127);
  localparam logic signed [ACC_W:0] SAT_MIN = (ACC_W+1)'(-128);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  // Requantize one element. The extra bit keeps z + rounding constant from
  // wrapping for every legal shift.
  function automatic logic [7:0] requant(input logic [ACC_W-1:0] z,
                                         input logic [4:0]       sh);
    logic signed [ACC_W:0] ext;
    logic signed [ACC_W:0] rnd;
    logic signed [ACC_W:0] r;
    ext = {z[ACC_W-1], z};
    rnd = (ACC_W+1)'(1) << (sh - 5'd1);
    if (sh == 5'd0) r = ext;
    else            r = (ext + rnd) >>> sh;
    if (r > SAT_MAX)      return 8'h7F;
    else if (r < SAT_MIN) return 8'h80;
    else                  return r[7:0];
  endfunction

  state_t               state_q, state_d;
  logic [1:0]           beat_q, beat_d;
  logic [ACC_W-1:0]     z_q [4];
  logic [4:0]           shift_q;
  logic                 packed_q;
  logic                 ovf_q, ovf_d;

  logic [31:0]          mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]     count_q, count_d;

  logic [CNT_W-1:0]     free_slots;
  logic [CNT_W-1:0]     need_slots;
  logic                 capture;
  logic                 push, pop;
  logic [7:0]           q [4];
  logic [31:0]          push_data;

  // Space check uses the registered count only; a same-cycle pop is not
  // credited. No push happens in IDLE, so count_q is exact here.
  assign free_slots = CNT_W'(FIFO_DEPTH) - count_q;
  assign need_slots = packed_mode ? CNT_W'(1) : CNT_W'(4);
  assign capture    = (state_q == IDLE) && res_valid && (free_slots >= need_slots);
  assign pop        = (count_q != '0) && rd_ready;

  // Any res_valid that is not captured (busy or no room) is a dropped set.
  always_comb begin
    ovf_d = ovf_q;
    if (clr_overflow)               ovf_d = 1'b0;
    if (res_valid && !capture)      ovf_d = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        if (capture) begin
          state_d = EMIT;
          beat_d  = 2'd0;
        end
      end
      EMIT: begin
        push   = 1'b1;
        beat_d = beat_q + 2'd1;
        if (packed_q || (beat_q == 2'd3)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      beat_q  <= 2'd0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) z_q[i] <= '0;
      shift_q  <= 5'd0;
      packed_q <= 1'b0;
    end else if (capture) begin
      z_q[0]   <= z11;
      z_q[1]   <= z12;
      z_q[2]   <= z21;
      z_q[3]   <= z22;
      shift_q  <= shift;
      packed_q <= packed_mode;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_quant
      assign q[gi] = requant(z_q[gi], shift_q);
    end
  endgenerate

  // Raw words are sign-extended from ACC_W to 32 bits.
  assign push_data = packed_q ? {q[3], q[2], q[1], q[0]}
                              : 32'($signed(z_q[beat_q]));

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  assign rd_valid   = (count_q != '0);
  assign rd_data    = rd_valid ? mem[rd_ptr_q] : 32'd0;
  assign fifo_count = count_q;
  assign busy       = (state_q == EMIT);
  assign overflow   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_result_drain.sv
`default_nettype none
// ============================================================================
// Module   : tb_result_drain
// Purpose  : Self-checking bench for result_drain: directed vector table,
//            hand-written multi-cycle sequences and a randomized run against
//            a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_result_drain;

  localparam int ACC_W = 32;
  localparam int DEPTH = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             res_valid;
  logic [ACC_W-1:0] z11, z12, z21, z22;
  logic [4:0]       shift;
  logic             packed_mode;
  logic [31:0]      rd_data;
  logic             rd_valid;
  logic             rd_ready;
  logic [3:0]       fifo_count;
  logic             busy;
  logic             overflow;
  logic             clr_overflow;

  result_drain #(.ACC_W(ACC_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .res_valid    (res_valid),
    .z11          (z11),
    .z12          (z12),
    .z21          (z21),
    .z22          (z22),
    .shift        (shift),
    .packed_mode  (packed_mode),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .fifo_count   (fifo_count),
    .busy         (busy),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one result set for a single cycle; returns in cycle N+1.
  task automatic fire(input logic pk, input logic [4:0] sh,
                      input int a, input int b, input int c, input int d);
    packed_mode = pk; shift = sh;
    z11 = a; z12 = b; z21 = c; z22 = d;
    res_valid = 1'b1;
    tick();
    res_valid = 1'b0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct packed {
    logic             pk;
    logic [4:0]       sh;
    logic [3:0][31:0] z;
    logic [2:0]       n;
    logic [3:0][31:0] w;
  } vec_t;

  function automatic vec_t mk(input logic pk, input int sh,
                              input int a, input int b, input int c, input int d,
                              input int n, input int w0, input int w1, input int w2, input int w3);
    vec_t v;
    v.pk = pk; v.sh = 5'(sh);
    v.z[0] = a; v.z[1] = b; v.z[2] = c; v.z[3] = d;
    v.n = 3'(n);
    v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3;
    return v;
  endfunction

  vec_t vecs [7];

  task automatic apply_vec(input vec_t v, input int idx);
    rd_ready = 1'b0;
    fire(v.pk, v.sh, int'(v.z[0]), int'(v.z[1]), int'(v.z[2]), int'(v.z[3]));
    repeat (5) tick();
    check($sformatf("vec%0d count", idx), 32'(fifo_count), 32'(v.n));
    check($sformatf("vec%0d overflow", idx), 32'(overflow), 32'd0);
    for (int i = 0; i < int'(v.n); i++) begin
      check($sformatf("vec%0d word%0d", idx, i), rd_data, v.w[i]);
      rd_ready = 1'b1;
      tick();
      rd_ready = 1'b0;
    end
    check($sformatf("vec%0d drained", idx), 32'(fifo_count), 32'd0);
  endtask

  // ---------------- reference model ----------------
  logic [31:0] mq[$];
  logic [31:0] pend[$];
  bit          movf;

  function automatic logic [7:0] ref_q(input int z, input int sh);
    real    v;
    longint r;
    v = $floor(real'(z) / (2.0 ** sh) + 0.5);
    r = longint'(v);
    if (r > 127)  return 8'h7F;
    if (r < -128) return 8'h80;
    return 8'(r);
  endfunction

  function automatic int rand_z();
    case ($urandom_range(0, 3))
      0:       return int'($urandom_range(0, 600)) - 300;
      1:       return int'($urandom_range(0, 80000)) - 40000;
      2:       return int'($urandom);
      default: return ($urandom_range(0, 1) != 0) ? 32'h7FFFFFFF : 32'h80000000;
    endcase
  endfunction

  task automatic model_step();
    bit          idle;
    bit          do_pop;
    bit          do_push;
    bit          setov;
    logic [31:0] pw;
    int          need;
    idle    = (pend.size() == 0);
    do_pop  = (mq.size() != 0) && rd_ready;
    do_push = !idle;
    setov   = 1'b0;
    pw      = '0;
    if (do_push) pw = pend.pop_front();
    if (res_valid) begin
      if (!idle) setov = 1'b1;
      else begin
        need = packed_mode ? 1 : 4;
        if (DEPTH - mq.size() >= need) begin
          if (packed_mode)
            pend.push_back({ref_q(int'(z22), int'(shift)), ref_q(int'(z21), int'(shift)),
                            ref_q(int'(z12), int'(shift)), ref_q(int'(z11), int'(shift))});
          else begin
            pend.push_back(z11); pend.push_back(z12);
            pend.push_back(z21); pend.push_back(z22);
          end
        end else setov = 1'b1;
      end
    end
    if (do_pop)  void'(mq.pop_front());
    if (do_push) mq.push_back(pw);
    if (setov)             movf = 1'b1;
    else if (clr_overflow) movf = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; res_valid = 1'b0; rd_ready = 1'b0; clr_overflow = 1'b0;
    packed_mode = 1'b0; shift = 5'd0; z11 = '0; z12 = '0; z21 = '0; z22 = '0;

    vecs[0] = mk(1'b1, 0, 5, -3, 200, -1000,             1, 32'h807FFD05, 0, 0, 0);
    vecs[1] = mk(1'b1, 4, 24, -24, 23, 0,                1, 32'h0001FF02, 0, 0, 0);
    vecs[2] = mk(1'b0, 0, 1, 2, 3, 4,                    4, 1, 2, 3, 4);
    vecs[3] = mk(1'b0, 7, -1, 32'h7FFFFFFF, 32'h80000000, 0,
                 4, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000, 0);
    vecs[4] = mk(1'b1, 1, 1, -1, 3, -3,                  1, 32'hFF020001, 0, 0, 0);
    vecs[5] = mk(1'b1, 31, 32'h7FFFFFFF, 32'h80000000, 32'h40000000, 0,
                 1, 32'h0001FF01, 0, 0, 0);
    vecs[6] = mk(1'b1, 8, 32767, -32768, 384, -384,      1, 32'hFF02807F, 0, 0, 0);

    // Reset state
    #12;
    check("rst rd_valid", 32'(rd_valid), 32'd0);
    check("rst rd_data", rd_data, 32'd0);
    check("rst count", 32'(fifo_count), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst overflow", 32'(overflow), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    tick();

    // Packed saturation with latency
    rd_ready = 1'b1;
    check("A N rd_valid", 32'(rd_valid), 32'd0);
    fire(1'b1, 5'd0, 5, -3, 200, -1000);
    check("A N+1 busy", 32'(busy), 32'd1);
    check("A N+1 rd_valid", 32'(rd_valid), 32'd0);
    tick();
    check("A N+2 rd_valid", 32'(rd_valid), 32'd1);
    check("A N+2 rd_data", rd_data, 32'h807FFD05);
    tick();
    check("A N+3 count", 32'(fifo_count), 32'd0);
    check("A N+3 busy", 32'(busy), 32'd0);

    // Raw order, latency and busy window
    fire(1'b0, 5'd0, 1, 2, 3, 4);
    check("B N+1 busy", 32'(busy), 32'd1);
    check("B N+1 rd_valid", 32'(rd_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("B N+%0d rd_valid", i + 2), 32'(rd_valid), 32'd1);
      check($sformatf("B N+%0d rd_data", i + 2), rd_data, 32'(i + 1));
      check($sformatf("B N+%0d busy", i + 2), 32'(busy), (i < 3) ? 32'd1 : 32'd0);
    end
    tick();
    check("B drained", 32'(fifo_count), 32'd0);

    // Vector table
    for (int i = 0; i < 7; i++) apply_vec(vecs[i], i);

    // Full FIFO
    rd_ready = 1'b0;
    fire(1'b0, 5'd0, 1, 2, 3, 4);
    repeat (5) tick();
    fire(1'b0, 5'd0, 5, 6, 7, 8);
    repeat (5) tick();
    check("C count full", 32'(fifo_count), 32'd8);
    check("C ovf before", 32'(overflow), 32'd0);
    fire(1'b1, 5'd0, 9, 9, 9, 9);
    check("C ovf set", 32'(overflow), 32'd1);
    check("C count kept", 32'(fifo_count), 32'd8);
    check("C not busy", 32'(busy), 32'd0);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    check("C ovf cleared", 32'(overflow), 32'd0);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("C drain%0d", i), rd_data, 32'(i + 1));
      rd_ready = 1'b1;
      tick();
      rd_ready = 1'b0;
    end
    check("C empty", 32'(fifo_count), 32'd0);
    check("C empty rd_data", rd_data, 32'd0);

    // Busy collision, then set-vs-clear priority
    fire(1'b0, 5'd0, 11, 12, 13, 14);
    tick();
    fire(1'b1, 5'd0, 99, 99, 99, 99);
    check("D ovf collision", 32'(overflow), 32'd1);
    check("D still busy", 32'(busy), 32'd1);
    res_valid = 1'b1; clr_overflow = 1'b1;
    tick();
    res_valid = 1'b0; clr_overflow = 1'b0;
    check("D set beats clr", 32'(overflow), 32'd1);
    repeat (3) tick();
    check("D count", 32'(fifo_count), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("D drain%0d", i), rd_data, 32'(i + 11));
      rd_ready = 1'b1;
      tick();
      rd_ready = 1'b0;
    end
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    check("D ovf cleared", 32'(overflow), 32'd0);

    // Reset mid-EMIT
    fire(1'b0, 5'd0, 21, 22, 23, 24);
    tick();
    tick();
    check("E count before rst", 32'(fifo_count), 32'd2);
    #2 reset = 1'b1;
    #1;
    check("E rst rd_valid", 32'(rd_valid), 32'd0);
    check("E rst count", 32'(fifo_count), 32'd0);
    check("E rst busy", 32'(busy), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    fire(1'b1, 5'd4, 24, -24, 23, 0);
    repeat (4) tick();
    check("E post count", 32'(fifo_count), 32'd1);
    check("E post word", rd_data, 32'h0001FF02);

    // Randomized run against the reference model
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mq.delete(); pend.delete(); movf = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      check("R rd_valid", 32'(rd_valid), 32'(mq.size() != 0));
      check("R rd_data", rd_data, (mq.size() != 0) ? mq[0] : 32'd0);
      check("R count", 32'(fifo_count), 32'(mq.size()));
      check("R busy", 32'(busy), 32'(pend.size() != 0));
      check("R overflow", 32'(overflow), 32'(movf));
      res_valid    = ($urandom_range(0, 99) < 30);
      rd_ready     = ($urandom_range(0, 99) < (((cyc / 400) % 2 != 0) ? 15 : 80));
      clr_overflow = ($urandom_range(0, 99) < 5);
      packed_mode  = $urandom_range(0, 1) != 0;
      shift        = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                                 : 5'($urandom_range(0, 10));
      z11 = rand_z(); z12 = rand_z(); z21 = rand_z(); z22 = rand_z();
      model_step();
      tick();
    end
    res_valid = 1'b0; rd_ready = 1'b0; clr_overflow = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/result_drain.md
Name: result_drain

Overview:
- Downstream stage of the matrix multiplier core.
- Snapshots the four 2x2 accumulator results (z11, z12, z21, z22) when control signals that they are final.
- Either passes them through raw or requantizes them (round, shift, saturate to int8) and packs them into one word.
- Buffers the resulting 32-bit words in a small FIFO that the bus-side reader drains with a valid/ready handshake.

Parameters:
- ACC_W, 32, accumulator width (equals 4*indata_size); legal range 9..32.
- FIFO_DEPTH, 8, number of 32-bit FIFO entries; power of two, minimum 4.

Ports:
- clk  input  1  single clock; all flops on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- res_valid  input  1  one-cycle pulse: z11..z22 hold final results this cycle.
- z11  input  ACC_W  signed result element (1,1).
- z12  input  ACC_W  signed result element (1,2).
- z21  input  ACC_W  signed result element (2,1).
- z22  input  ACC_W  signed result element (2,2).
- shift  input  5  requantization right-shift amount; sampled with res_valid.
- packed_mode  input  1  1 = emit one packed int8 word; 0 = emit four raw words; sampled with res_valid.
- rd_data  output  32  FIFO head word.
- rd_valid  output  1  FIFO is non-empty.
- rd_ready  input  1  reader accepts the head word.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  number of occupied entries.
- busy  output  1  capture FSM is not in IDLE.
- overflow  output  1  sticky: a result set was dropped.
- clr_overflow  input  1  clears overflow.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state = IDLE; FIFO empty; fifo_count = 0; rd_valid = 0; rd_data = 0; busy = 0; overflow = 0.
  - Capture registers = 0.
  - FIFO storage need not be reset.
- Reset during EMIT aborts the emission; no partial words survive.
- FSM states: IDLE and EMIT.
- Capture, in IDLE, on a res_valid cycle:
  - Needed space = 4 entries (raw) or 1 entry (packed).
  - If (FIFO_DEPTH - fifo_count) >= needed space: snapshot z11..z22, shift and packed_mode into capture registers, go to EMIT, load beat counter = 0.
  - A pop in the same cycle is not credited (conservative check).
  - Otherwise drop the set and set overflow.
- res_valid while in EMIT: the set is dropped, overflow is set, emission continues unaffected.
- EMIT, raw mode: one FIFO write per cycle, in the order z11, z12, z21, z22, each sign-extended or truncated to 32 bits (lower 32 bits when ACC_W = 32). Return to IDLE after beat 3.
- EMIT, packed mode: one FIFO write of {q22, q21, q12, q11}, with q11 in bits [7:0]. Return to IDLE.
- The capture-time space check guarantees EMIT never writes to a full FIFO.
- Requantization, per element, computed in ACC_W+1 bits signed:
  - shift = 0: r = z.
  - shift > 0: r = (z + (1 << (shift-1))) >>> shift, i.e. round half up.
  - q = saturate r to [-128, 127], two's complement 8 bits.
- Latency:
  - res_valid is sampled in cycle N.
  - The first FIFO write occurs at the end of cycle N+1.
  - rd_valid is first high in cycle N+2.
  - Raw mode: busy is high in cycles N+1..N+4.
- FIFO:
  - First-word-fall-through; rd_valid = (fifo_count != 0).
  - rd_data = head entry when non-empty, 0 when empty.
  - Pop on rd_valid && rd_ready; rd_ready while empty is ignored.
  - Simultaneous push and pop: fifo_count is unchanged, data order is preserved.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- overflow: sticky. clr_overflow clears it on the next edge. If a set event and clr_overflow occur in the same cycle, the set wins.

Test Plan:
- Packed saturation: packed_mode=1, shift=0, z11=5, z12=-3, z21=200, z22=-1000, rd_ready=1 -> one word 0x807FFD05 with rd_valid in cycle N+2; fifo_count returns to 0.
- Packed rounding: shift=4, z11=24, z12=-24, z21=23, z22=0 -> q = 2, -1, 1, 0 -> word 0x0001FF02.
- Raw order and latency: packed_mode=0, z=1,2,3,4, rd_ready=1 -> rd_data = 1, 2, 3, 4 in cycles N+2..N+5; busy high in cycles N+1..N+4.
- Full FIFO: FIFO_DEPTH=8, rd_ready=0; two raw sets fill fifo_count to 8; a third res_valid -> dropped, overflow=1, count stays 8. Then clr_overflow=1 -> overflow=0; drain returns all 8 words in order.
- Busy collision: a second res_valid during EMIT of a raw set -> only 4 words are written, overflow=1. A res_valid together with clr_overflow in the same cycle -> overflow stays 1.
- Reset mid-EMIT: assert reset after beat 1 of a raw set -> rd_valid=0, fifo_count=0 and busy=0 immediately; the next packed set after reset is emitted correctly.
